// File: rtl/ilv2_mode_ctrl.sv
// rtl/ilv2_mode_ctrl.sv - run-time bypass/interleave mode sequencer for the ilv2 lane datapath
//
// Switches one lane between bypass and odd/even interleaved output, only on
// frame boundaries. Valid words are counted into frames; a switch request is
// armed and then committed on the next boundary word.
//
// Ports
//   clk         single clock
//   sclr        synchronous clear, active high, overrides every other input
//   din         input word, {din_high, din_low}
//   din_valid   din qualifier, gaps allowed on any cycle
//   frame_sync  with din_valid: this word is frame word 0
//   ilv_req     level request, 1 = interleave
//   dout        registered output word, holds during invalid cycles
//   dout_valid  dout qualifier
//   ilv_ack     interleaved mode active
//   busy        switch armed, waiting for a boundary word
//   switch_cnt  completed mode switches, saturating
module ilv2_mode_ctrl #(
    parameter int WIDTH       = 40,
    parameter int FRAME_WORDS = 32,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    input  logic             ilv_req,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             ilv_ack,
    output logic             busy,
    output logic [CNT_W-1:0] switch_cnt
);

    localparam int HALF = WIDTH / 2;
    localparam int WC_W = (FRAME_WORDS > 2) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [WC_W-1:0] LAST_IDX = WC_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        S_BYP     = 2'd0,
        S_ARM_ON  = 2'd1,
        S_ILV     = 2'd2,
        S_ARM_OFF = 2'd3
    } state_t;

    state_t            state;
    logic [WC_W-1:0]   word_cnt;
    logic [HALF-1:0]   prev_high;

    logic [HALF-1:0]   din_high;
    logic [HALF-1:0]   din_low;
    logic [WC_W-1:0]   word_idx;
    logic [WC_W-1:0]   wc_next;
    logic              boundary;
    logic [WIDTH-1:0]  mixed;
    logic [CNT_W-1:0]  cnt_inc;

    // Even output bits carry the current low half, odd bits the held high half.
    function automatic logic [WIDTH-1:0] mix_odd_even(input logic [HALF-1:0] h,
                                                      input logic [HALF-1:0] l);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < HALF; i++) begin
            r[2*i]   = l[i];
            r[2*i+1] = h[i];
        end
        return r;
    endfunction

    always_comb begin
        din_high = din[WIDTH-1:HALF];
        din_low  = din[HALF-1:0];
        // frame_sync forces the current word to index 0 whatever the count says.
        word_idx = frame_sync ? '0 : word_cnt;
        wc_next  = (word_idx == LAST_IDX) ? '0 : word_idx + 1'b1;
        boundary = din_valid && (word_idx == '0);
        mixed    = mix_odd_even(prev_high, din_low);
        cnt_inc  = (switch_cnt == '1) ? switch_cnt : switch_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state      <= S_BYP;
            word_cnt   <= '0;
            prev_high  <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ilv_ack    <= 1'b0;
            busy       <= 1'b0;
            switch_cnt <= '0;
        end else begin
            dout_valid <= 1'b0;
            if (din_valid) begin
                word_cnt <= wc_next;
            end

            case (state)
                S_BYP: begin
                    if (din_valid) begin
                        dout       <= din;
                        dout_valid <= 1'b1;
                    end
                    if (ilv_req) begin
                        state <= S_ARM_ON;
                        busy  <= 1'b1;
                    end
                end

                S_ARM_ON: begin
                    if (!ilv_req) begin
                        // Request withdrawn: abandon, even on a boundary word.
                        if (din_valid) begin
                            dout       <= din;
                            dout_valid <= 1'b1;
                        end
                        state <= S_BYP;
                        busy  <= 1'b0;
                    end else if (boundary) begin
                        // The entry word only primes the high-half history;
                        // its own output would pair with a stale half, so drop it.
                        prev_high  <= din_high;
                        state      <= S_ILV;
                        ilv_ack    <= 1'b1;
                        busy       <= 1'b0;
                        switch_cnt <= cnt_inc;
                    end else if (din_valid) begin
                        dout       <= din;
                        dout_valid <= 1'b1;
                    end
                end

                S_ILV: begin
                    if (din_valid) begin
                        dout       <= mixed;
                        dout_valid <= 1'b1;
                        prev_high  <= din_high;
                    end
                    if (!ilv_req) begin
                        state <= S_ARM_OFF;
                        busy  <= 1'b1;
                    end
                end

                S_ARM_OFF: begin
                    if (din_valid) begin
                        prev_high <= din_high;
                    end
                    if (ilv_req) begin
                        if (din_valid) begin
                            dout       <= mixed;
                            dout_valid <= 1'b1;
                        end
                        state <= S_ILV;
                        busy  <= 1'b0;
                    end else if (boundary) begin
                        // Exit word goes out as plain bypass; the held half is dropped.
                        dout       <= din;
                        dout_valid <= 1'b1;
                        state      <= S_BYP;
                        ilv_ack    <= 1'b0;
                        busy       <= 1'b0;
                        switch_cnt <= cnt_inc;
                    end else if (din_valid) begin
                        dout       <= mixed;
                        dout_valid <= 1'b1;
                    end
                end

                default: begin
                    state <= S_BYP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ilv2_mode_ctrl.sv
// tb/tb_ilv2_mode_ctrl.sv - self-checking bench for ilv2_mode_ctrl against a behavioural model
module tb_ilv2_mode_ctrl;

    localparam int W  = 8;
    localparam int FW = 4;

    logic         clk = 1'b0;
    logic         sclr = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         frame_sync = 1'b0;
    logic         ilv_req = 1'b0;

    logic [W-1:0] dout, dout_s;
    logic         dout_valid, dout_valid_s;
    logic         ilv_ack, ilv_ack_s;
    logic         busy, busy_s;
    logic [7:0]   switch_cnt;
    logic [1:0]   switch_cnt_s;

    int checks = 0;
    int errors = 0;

    // Reference model: active mode, pending-switch flag, history half,
    // frame position, last output word and switch counts.
    bit           m_ilv;
    bit           m_pend;
    logic [3:0]   m_prev;
    int           m_pos;
    logic [W-1:0] m_dout;
    bit           m_dv;
    int           m_cnt;
    int           m_cnt_sat;

    always #5 clk = ~clk;

    ilv2_mode_ctrl #(.WIDTH(W), .FRAME_WORDS(FW), .CNT_W(8)) u_dut (
        .clk(clk), .sclr(sclr), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .ilv_req(ilv_req),
        .dout(dout), .dout_valid(dout_valid), .ilv_ack(ilv_ack),
        .busy(busy), .switch_cnt(switch_cnt)
    );

    ilv2_mode_ctrl #(.WIDTH(W), .FRAME_WORDS(FW), .CNT_W(2)) u_sat (
        .clk(clk), .sclr(sclr), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .ilv_req(ilv_req),
        .dout(dout_s), .dout_valid(dout_valid_s), .ilv_ack(ilv_ack_s),
        .busy(busy_s), .switch_cnt(switch_cnt_s)
    );

    function automatic logic [W-1:0] ref_mix(input logic [3:0] h, input logic [3:0] l);
        logic [W-1:0] r;
        for (int i = 0; i < 4; i++) begin
            r[2*i]   = l[i];
            r[2*i+1] = h[i];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [W-1:0] d, input bit v, input bit fs, input bit r, input bit s);
        int  idx;
        bit  bnd;
        bit  switched;
        if (s) begin
            m_ilv = 0; m_pend = 0; m_prev = '0; m_pos = 0;
            m_dout = '0; m_dv = 0; m_cnt = 0; m_cnt_sat = 0;
            return;
        end
        idx      = fs ? 0 : m_pos;
        bnd      = v && (idx == 0);
        switched = 0;
        m_dv     = 0;
        if (v) begin
            if (!m_ilv) begin
                if (m_pend && r && bnd) begin
                    m_prev = d[7:4];
                    m_ilv  = 1;
                    switched = 1;
                end else begin
                    m_dout = d;
                    m_dv   = 1;
                end
            end else begin
                if (m_pend && !r && bnd) begin
                    m_dout = d;
                    m_dv   = 1;
                    m_ilv  = 0;
                    switched = 1;
                end else begin
                    m_dout = ref_mix(m_prev, d[3:0]);
                    m_dv   = 1;
                    m_prev = d[7:4];
                end
            end
            m_pos = (idx + 1) % FW;
        end
        if (switched) begin
            m_pend = 0;
            if (m_cnt < 255) m_cnt++;
            if (m_cnt_sat < 3) m_cnt_sat++;
        end else begin
            // A switch is armed exactly while the request disagrees with the active mode.
            m_pend = (r != m_ilv);
        end
    endtask

    task automatic step(input logic [W-1:0] d, input bit v, input bit fs, input bit r, input bit s);
        din = d; din_valid = v; frame_sync = fs; ilv_req = r; sclr = s;
        model(d, v, fs, r, s);
        @(posedge clk);
        #1;
        chk("dout", 32'(dout), 32'(m_dout));
        chk("dout_valid", 32'(dout_valid), 32'(m_dv));
        chk("ilv_ack", 32'(ilv_ack), 32'(m_ilv));
        chk("busy", 32'(busy), 32'(m_pend));
        chk("switch_cnt", 32'(switch_cnt), 32'(m_cnt));
        chk("sat_dout", 32'(dout_s), 32'(m_dout));
        chk("sat_switch_cnt", 32'(switch_cnt_s), 32'(m_cnt_sat));
    endtask

    initial begin
        bit req_r;

        // Reset with active-looking input
        for (int i = 0; i < 3; i++) step(8'hA5, 1, 0, 0, 1);
        chk("reset_dout", 32'(dout), 32'h0);
        chk("reset_cnt", 32'(switch_cnt), 32'h0);

        // Bypass
        step(8'h12, 1, 1, 0, 0);
        chk("byp_12", 32'(dout), 32'h12);
        step(8'h34, 1, 0, 0, 0);
        chk("byp_34", 32'(dout), 32'h34);

        // Entry: arm at idx 2, F0 passes, 3C dropped, 5A -> 4E
        step(8'h77, 1, 0, 1, 0);
        step(8'hF0, 1, 0, 1, 0);
        chk("entry_f0", 32'(dout), 32'hF0);
        step(8'h3C, 1, 0, 1, 0);
        chk("entry_drop", 32'(dout_valid), 32'h0);
        chk("entry_cnt", 32'(switch_cnt), 32'h1);
        step(8'h5A, 1, 0, 1, 0);
        chk("entry_mix", 32'(dout), 32'h4E);
        chk("entry_ack", 32'(ilv_ack), 32'h1);

        // Gap hold
        for (int i = 0; i < 3; i++) step(8'hFF, 0, 0, 1, 0);
        step(8'hC6, 1, 0, 1, 0);
        chk("gap_mix", 32'(dout), 32'(ref_mix(4'h5, 4'h6)));

        // Exit at next boundary
        step(8'h81, 1, 0, 0, 0);
        chk("exit_busy", 32'(busy), 32'h1);
        step(8'h9D, 1, 0, 0, 0);
        chk("exit_dout", 32'(dout), 32'h9D);
        chk("exit_ack", 32'(ilv_ack), 32'h0);
        chk("exit_cnt", 32'(switch_cnt), 32'h2);

        // One-word request pulse in bypass aborts
        step(8'h11, 1, 0, 1, 0);
        step(8'h22, 1, 0, 0, 0);
        chk("abort_cnt", 32'(switch_cnt), 32'h2);

        // frame_sync realign while armed
        step(8'h33, 1, 0, 0, 0);
        step(8'h44, 1, 0, 0, 0);
        step(8'h55, 1, 0, 1, 0);
        step(8'h66, 1, 1, 1, 0);
        chk("realign_cnt", 32'(switch_cnt), 32'h3);
        chk("realign_drop", 32'(dout_valid), 32'h0);

        // Reset while ARM_OFF
        step(8'h77, 1, 0, 0, 0);
        step(8'h00, 0, 0, 0, 1);
        chk("sclr_armoff_ack", 32'(ilv_ack), 32'h0);

        // Five switches: the 2-bit counter must stick at 3
        req_r = 0;
        for (int k = 0; k < 5; k++) begin
            req_r = !req_r;
            for (int j = 0; j < 5; j++) step(8'(k * 16 + j), 1, 0, req_r, 0);
        end
        chk("sat5_main", 32'(switch_cnt), 32'h5);
        chk("sat5_cnt", 32'(switch_cnt_s), 32'h3);

        // Randomized traffic
        req_r = ilv_req;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 9) == 0) req_r = !req_r;
            step(8'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
                 req_r, ($urandom_range(0, 149) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
